// File: rtl/snake_defs.sv
// Shared PS/2 set-2 scan codes and the one-hot direction format used by the game logic.
package snake_defs;

  localparam int DIR_W     = 4;
  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Zero for anything that is not an arrow make code.
  function automatic logic [DIR_W-1:0] dir_onehot(input logic [7:0] code);
    dir_onehot = '0;
    case (code)
      SC_UP:    dir_onehot[DIR_UP]    = 1'b1;
      SC_DOWN:  dir_onehot[DIR_DOWN]  = 1'b1;
      SC_LEFT:  dir_onehot[DIR_LEFT]  = 1'b1;
      SC_RIGHT: dir_onehot[DIR_RIGHT] = 1'b1;
      default:  dir_onehot = '0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver: synchroniser, clock glitch filter, frame FSM, timeout.
// state    | meaning
// S_IDLE   | waiting for a start bit (data 0 on a filtered fall)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | capturing the odd-parity bit
// S_STOP   | checking stop bit and parity, then publishing byte or error
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 106470
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Ps2Clk,
  input  logic       i_Ps2Data,
  output logic [7:0] o_Byte,
  output logic       o_ByteValid,
  output logic       o_FrameErr
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [1:0]    r_ClkSync;
  logic [1:0]    r_DatSync;
  logic          r_ClkFilt;
  logic [FW-1:0] r_FiltCnt;
  logic          r_Fall;
  logic [1:0]    r_State;
  logic [7:0]    r_Shift;
  logic [2:0]    r_BitCnt;
  logic          r_Parity;
  logic [TW-1:0] r_ToCnt;

  logic w_ClkS;
  logic w_DatS;
  logic w_Timeout;

  assign w_ClkS    = r_ClkSync[1];
  assign w_DatS    = r_DatSync[1];
  assign w_Timeout = (r_State != S_IDLE) && !r_Fall && (r_ToCnt == TO_LAST);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_ClkSync <= 2'b11;
      r_DatSync <= 2'b11;
    end else begin
      r_ClkSync <= {r_ClkSync[0], i_Ps2Clk};
      r_DatSync <= {r_DatSync[0], i_Ps2Data};
    end
  end

  // The filter counts consecutive samples that disagree with the filtered level.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_ClkFilt <= 1'b1;
      r_FiltCnt <= '0;
      r_Fall    <= 1'b0;
    end else begin
      r_Fall <= 1'b0;
      if (w_ClkS == r_ClkFilt) begin
        r_FiltCnt <= '0;
      end else if (r_FiltCnt == FILT_LAST) begin
        r_ClkFilt <= w_ClkS;
        r_FiltCnt <= '0;
        r_Fall    <= r_ClkFilt;
      end else begin
        r_FiltCnt <= r_FiltCnt + 1'b1;
      end
    end
  end

  // Counts cycles since the last fall, so the abort lands TIMEOUT_CYCLES after it.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_ToCnt <= '0;
    end else if (r_Fall) begin
      r_ToCnt <= TW'(1);
    end else if (r_State == S_IDLE || w_Timeout) begin
      r_ToCnt <= '0;
    end else begin
      r_ToCnt <= r_ToCnt + 1'b1;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_State     <= S_IDLE;
      r_Shift     <= '0;
      r_BitCnt    <= '0;
      r_Parity    <= 1'b0;
      o_Byte      <= '0;
      o_ByteValid <= 1'b0;
      o_FrameErr  <= 1'b0;
    end else begin
      o_ByteValid <= 1'b0;
      o_FrameErr  <= 1'b0;
      if (w_Timeout) begin
        o_FrameErr <= 1'b1;
        r_State    <= S_IDLE;
      end else if (r_Fall) begin
        case (r_State)
          S_IDLE: begin
            if (!w_DatS) begin
              r_State  <= S_DATA;
              r_BitCnt <= '0;
            end
          end
          S_DATA: begin
            r_Shift  <= {w_DatS, r_Shift[7:1]};
            r_BitCnt <= r_BitCnt + 1'b1;
            if (r_BitCnt == 3'd7) r_State <= S_PARITY;
          end
          S_PARITY: begin
            r_Parity <= w_DatS;
            r_State  <= S_STOP;
          end
          S_STOP: begin
            if (w_DatS && (^{r_Parity, r_Shift})) begin
              o_Byte      <= r_Shift;
              o_ByteValid <= 1'b1;
            end else begin
              o_FrameErr <= 1'b1;
            end
            r_State <= S_IDLE;
          end
          default: r_State <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_direction_receiver.sv
// Decodes extended set-2 arrow make codes from a PS/2 keyboard into a sticky one-hot direction.
module ps2_direction_receiver
  import snake_defs::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 106470
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Ps2Clk,
  input  logic             i_Ps2Data,
  output logic [7:0]       o_Byte,
  output logic             o_ByteValid,
  output logic             o_FrameErr,
  output logic [DIR_W-1:0] o_Direction,
  output logic             o_DirValid
);

  logic [7:0]       w_Byte;
  logic             w_ByteValid;
  logic             w_FrameErr;
  logic [DIR_W-1:0] w_DirCode;

  logic             r_Ext;
  logic             r_Brk;
  logic [DIR_W-1:0] r_Direction;
  logic             r_DirValid;

  ps2_frame_rx #(
    .FILTER_LEN     (FILTER_LEN),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame_rx (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Ps2Clk    (i_Ps2Clk),
    .i_Ps2Data   (i_Ps2Data),
    .o_Byte      (w_Byte),
    .o_ByteValid (w_ByteValid),
    .o_FrameErr  (w_FrameErr)
  );

  assign w_DirCode = dir_onehot(w_Byte);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_Ext       <= 1'b0;
      r_Brk       <= 1'b0;
      r_Direction <= '0;
      r_DirValid  <= 1'b0;
    end else begin
      r_DirValid <= 1'b0;
      if (w_FrameErr) begin
        r_Ext <= 1'b0;
        r_Brk <= 1'b0;
      end else if (w_ByteValid) begin
        if (w_Byte == SC_EXT) begin
          r_Ext <= 1'b1;
        end else if (w_Byte == SC_BRK) begin
          r_Brk <= 1'b1;
        end else begin
          // Only extended make codes steer; break and plain codes just consume the prefixes.
          if (r_Ext && !r_Brk && (w_DirCode != '0)) begin
            r_Direction <= w_DirCode;
            r_DirValid  <= 1'b1;
          end
          r_Ext <= 1'b0;
          r_Brk <= 1'b0;
        end
      end
    end
  end

  assign o_Byte      = w_Byte;
  assign o_ByteValid = w_ByteValid;
  assign o_FrameErr  = w_FrameErr;
  assign o_Direction = r_Direction;
  assign o_DirValid  = r_DirValid;

endmodule

// File: tb/tb_ps2_direction_receiver.sv
// Directed bench: table of PS/2 frames with expected decode, plus timeout, reset and glitch sequences.
module tb_ps2_direction_receiver;

  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2clk;
  logic       ps2dat;
  logic [7:0] o_Byte;
  logic       o_ByteValid;
  logic       o_FrameErr;
  logic [3:0] o_Direction;
  logic       o_DirValid;

  ps2_direction_receiver #(
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_Ps2Clk    (ps2clk),
    .i_Ps2Data   (ps2dat),
    .o_Byte      (o_Byte),
    .o_ByteValid (o_ByteValid),
    .o_FrameErr  (o_FrameErr),
    .o_Direction (o_Direction),
    .o_DirValid  (o_DirValid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_bv = 0;
  int         n_err = 0;
  int         n_dv = 0;
  logic [7:0] last_byte = 8'h00;
  always @(negedge clk) begin
    if (o_ByteValid) begin
      n_bv      <= n_bv + 1;
      last_byte <= o_Byte;
    end
    if (o_FrameErr) n_err <= n_err + 1;
    if (o_DirValid) n_dv <= n_dv + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int last_fall = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic v, input bit glitch);
    ps2dat = v;
    tick(HALF);
    ps2clk = 1'b0;
    last_fall = cyc;
    tick(HALF);
    ps2clk = 1'b1;
    if (glitch) begin
      tick(HALF / 2);
      ps2clk = 1'b0;
      tick(3);
      ps2clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int glitch_bit);
    logic p;
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0, glitch_bit == 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch_bit == i + 1);
    ps2_bit(p, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2dat = 1'b1;
    tick(20);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         bad_par;
    int         exp_bv;
    int         exp_err;
    int         exp_dv;
    logic [3:0] exp_dir;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int b0, e0, d0, bad, t_err;
    bit found;
    logic [7:0] pb;

    vecs[0]  = '{8'hE0, 1'b0, 1, 0, 0, 4'b0000};
    vecs[1]  = '{8'h75, 1'b0, 1, 0, 1, 4'b0001};
    vecs[2]  = '{8'hE0, 1'b0, 1, 0, 0, 4'b0001};
    vecs[3]  = '{8'hF0, 1'b0, 1, 0, 0, 4'b0001};
    vecs[4]  = '{8'h75, 1'b0, 1, 0, 0, 4'b0001};
    vecs[5]  = '{8'h74, 1'b0, 1, 0, 0, 4'b0001};
    vecs[6]  = '{8'hE0, 1'b0, 1, 0, 0, 4'b0001};
    vecs[7]  = '{8'h6B, 1'b1, 0, 1, 0, 4'b0001};
    vecs[8]  = '{8'h6B, 1'b0, 1, 0, 0, 4'b0001};
    vecs[9]  = '{8'hE0, 1'b0, 1, 0, 0, 4'b0001};
    vecs[10] = '{8'h6B, 1'b0, 1, 0, 1, 4'b0100};
    vecs[11] = '{8'hE0, 1'b0, 1, 0, 0, 4'b0100};
    vecs[12] = '{8'h6B, 1'b0, 1, 0, 1, 4'b0100};

    rst    = 1'b1;
    ps2clk = 1'b1;
    ps2dat = 1'b1;
    tick(3);
    check("rst_outputs", {o_Byte, o_ByteValid, o_FrameErr, o_Direction, o_DirValid}, 32'h0);
    rst = 1'b0;
    tick(1);
    check("post_rst_outputs", {o_Byte, o_ByteValid, o_FrameErr, o_Direction, o_DirValid}, 32'h0);

    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      tick(1);
      if (o_Direction != 4'b0000 || o_DirValid || o_ByteValid || o_FrameErr) bad++;
    end
    check("idle_quiet", bad, 0);
    check("idle_pulses", n_bv + n_err + n_dv, 0);

    for (int v = 0; v < 13; v++) begin
      b0 = n_bv; e0 = n_err; d0 = n_dv;
      send_frame(vecs[v].code, vecs[v].bad_par, -1);
      check($sformatf("v%0d_bytevalid_cnt", v), n_bv - b0, vecs[v].exp_bv);
      if (vecs[v].exp_bv != 0) check($sformatf("v%0d_byte", v), last_byte, vecs[v].code);
      check($sformatf("v%0d_frameerr_cnt", v), n_err - e0, vecs[v].exp_err);
      check($sformatf("v%0d_dirvalid_cnt", v), n_dv - d0, vecs[v].exp_dv);
      check($sformatf("v%0d_direction", v), o_Direction, vecs[v].exp_dir);
    end

    // Partial frame: start plus four data bits, then the clock stops.
    e0 = n_err; b0 = n_bv;
    pb = 8'h72;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(pb[i], 1'b0);
    found = 1'b0;
    t_err = 0;
    for (int i = 0; i < TO + 100 && !found; i++) begin
      tick(1);
      if (o_FrameErr) begin
        found = 1'b1;
        t_err = cyc;
      end
    end
    check("timeout_seen", found, 1);
    check("timeout_latency", t_err - last_fall, TO + FL + 2);
    tick(5);
    check("timeout_err_cnt", n_err - e0, 1);
    check("timeout_no_byte", n_bv - b0, 0);

    d0 = n_dv;
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'h72, 1'b0, -1);
    check("after_timeout_dir", o_Direction, 4'b0010);
    check("after_timeout_dv", n_dv - d0, 1);

    e0 = n_err;
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("midrst_dir_cleared", o_Direction, 4'b0000);
    tick(TO + 50);
    check("midrst_no_err", n_err - e0, 0);
    b0 = n_bv; d0 = n_dv;
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'h6B, 1'b0, -1);
    check("midrst_bv_cnt", n_bv - b0, 2);
    check("midrst_byte", last_byte, 8'h6B);
    check("midrst_dir", o_Direction, 4'b0100);
    check("midrst_dv", n_dv - d0, 1);

    b0 = n_bv; e0 = n_err; d0 = n_dv;
    send_frame(8'hE0, 1'b0, -1);
    send_frame(8'h74, 1'b0, 3);
    check("glitch_bv_cnt", n_bv - b0, 2);
    check("glitch_byte", last_byte, 8'h74);
    check("glitch_no_err", n_err - e0, 0);
    check("glitch_dir", o_Direction, 4'b1000);
    check("glitch_dv", n_dv - d0, 1);

    $display("Result: errors=%0d of %0d checks", n_fail, n_checks);
    $finish;
  end

endmodule
